// File: rtl/gnrc_xbar_sched.sv
// Single-iteration iSLIP scheduler for an N_IN x N_OUT packet crossbar.
// Each match is held until the last beat of its packet handshakes on the output.
module gnrc_xbar_sched #(
  parameter int unsigned                  N_IN  = 4,
  parameter int unsigned                  N_OUT = 4,
  parameter logic [N_IN-1:0][N_OUT-1:0]   MAP   = '1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [N_IN-1:0][N_OUT-1:0]            req_i,
  input  logic [N_OUT-1:0]                      fire_i,
  input  logic [N_OUT-1:0]                      last_i,
  output logic [N_OUT-1:0]                      match_valid_o,
  output logic [N_OUT-1:0][$clog2(N_IN)-1:0]    match_src_o,
  output logic [N_IN-1:0]                       in_busy_o,
  output logic [N_IN-1:0][$clog2(N_OUT)-1:0]    in_dest_o,
  output logic                                  err_o
);

  localparam int unsigned IdW   = $clog2(N_IN);
  localparam int unsigned DestW = $clog2(N_OUT);

  typedef logic [IdW-1:0]   id_t;
  typedef logic [DestW-1:0] dest_t;

  function automatic id_t wrap_id(int unsigned base, int unsigned k);
    return id_t'((base + k) % N_IN);
  endfunction

  function automatic dest_t wrap_dest(int unsigned base, int unsigned k);
    return dest_t'((base + k) % N_OUT);
  endfunction

  logic [N_OUT-1:0]             lock_q, lock_d;
  id_t  [N_OUT-1:0]             src_q, src_d;
  logic [N_IN-1:0]              busy_q, busy_d;
  dest_t [N_IN-1:0]             dst_q, dst_d;
  id_t  [N_OUT-1:0]             g_ptr_q, g_ptr_d;
  dest_t [N_IN-1:0]             a_ptr_q, a_ptr_d;
  logic                         err_q, err_d;

  logic [N_OUT-1:0]             rel, out_free, gnt_v;
  logic [N_IN-1:0]              in_free, acc_v;
  id_t  [N_OUT-1:0]             gnt_id;
  dest_t [N_IN-1:0]             acc_dst;

  // Free resources: anything idle, plus anything whose packet ends this cycle.
  always_comb begin
    rel      = lock_q & fire_i & last_i;
    out_free = ~lock_q | rel;
    for (int unsigned n = 0; n < N_IN; n++) begin
      in_free[n] = ~busy_q[n] | rel[dst_q[n]];
    end
  end

  // Grant: each free output scans requesters circularly from its pointer.
  always_comb begin
    gnt_v  = '0;
    gnt_id = '0;
    for (int unsigned m = 0; m < N_OUT; m++) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (!gnt_v[m] && out_free[m] && req_i[wrap_id(32'(g_ptr_q[m]), k)][m] &&
            MAP[wrap_id(32'(g_ptr_q[m]), k)][m] && in_free[wrap_id(32'(g_ptr_q[m]), k)]) begin
          gnt_v[m]  = 1'b1;
          gnt_id[m] = wrap_id(32'(g_ptr_q[m]), k);
        end
      end
    end
  end

  // Accept: each input scans granting outputs circularly from its pointer.
  always_comb begin
    acc_v   = '0;
    acc_dst = '0;
    for (int unsigned n = 0; n < N_IN; n++) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (!acc_v[n] && gnt_v[wrap_dest(32'(a_ptr_q[n]), k)] &&
            gnt_id[wrap_dest(32'(a_ptr_q[n]), k)] == id_t'(n)) begin
          acc_v[n]   = 1'b1;
          acc_dst[n] = wrap_dest(32'(a_ptr_q[n]), k);
        end
      end
    end
  end

  always_comb begin
    lock_d  = lock_q & ~rel;
    src_d   = src_q;
    busy_d  = busy_q;
    dst_d   = dst_q;
    g_ptr_d = g_ptr_q;
    a_ptr_d = a_ptr_q;
    for (int unsigned n = 0; n < N_IN; n++) begin
      if (busy_q[n] && rel[dst_q[n]]) begin
        busy_d[n] = 1'b0;
      end
    end
    // New accepts override the release defaults, giving bubble-free handover.
    for (int unsigned n = 0; n < N_IN; n++) begin
      if (acc_v[n]) begin
        lock_d[acc_dst[n]]  = 1'b1;
        src_d[acc_dst[n]]   = id_t'(n);
        busy_d[n]           = 1'b1;
        dst_d[n]            = acc_dst[n];
        g_ptr_d[acc_dst[n]] = wrap_id(n, 1);
        a_ptr_d[n]          = wrap_dest(32'(acc_dst[n]), 1);
      end
    end
    err_d = err_q | (|(fire_i & ~lock_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      lock_q  <= '0;
      src_q   <= '0;
      busy_q  <= '0;
      dst_q   <= '0;
      g_ptr_q <= '0;
      a_ptr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      dst_q   <= dst_d;
      g_ptr_q <= g_ptr_d;
      a_ptr_q <= a_ptr_d;
      err_q   <= err_d;
    end
  end

  assign match_valid_o = lock_q;
  assign match_src_o   = src_q;
  assign in_busy_o     = busy_q;
  assign in_dest_o     = dst_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_gnrc_xbar_sched.sv
// Bench for gnrc_xbar_sched: directed literal checks plus a randomized run
// compared every cycle against a matching model built from the scheduling rules.
module tb_gnrc_xbar_sched;

  localparam logic [15:0] MAPV = 16'hEFFF;  // input 3 may not reach output 0

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [3:0][3:0]  req;
  logic [3:0]       fire, last;
  logic [3:0]       mvalid;
  logic [3:0][1:0]  msrc;
  logic [3:0]       ibusy;
  logic [3:0][1:0]  idest;
  logic             err;

  gnrc_xbar_sched #(
    .N_IN  (4),
    .N_OUT (4),
    .MAP   (MAPV)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .req_i         (req),
    .fire_i        (fire),
    .last_i        (last),
    .match_valid_o (mvalid),
    .match_src_o   (msrc),
    .in_busy_o     (ibusy),
    .in_dest_o     (idest),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 0;

  // Model state (current and next).
  int m_lock[4], m_src[4], m_busy[4], m_dst[4], m_gp[4], m_ap[4];
  int n_lock[4], n_src[4], n_busy[4], n_dst[4], n_gp[4], n_ap[4];
  bit m_err, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic void model_step();
    bit rel[4], ofree[4], ifree[4], gv[4], found;
    int gid[4], c;
    n_lock = m_lock; n_src = m_src; n_busy = m_busy; n_dst = m_dst;
    n_gp = m_gp; n_ap = m_ap; n_err = m_err;
    if (rst || flush) begin
      for (int i = 0; i < 4; i++) begin
        n_lock[i] = 0; n_src[i] = 0; n_busy[i] = 0; n_dst[i] = 0; n_gp[i] = 0; n_ap[i] = 0;
      end
      n_err = 0;
      return;
    end
    for (int m = 0; m < 4; m++) begin
      rel[m]   = (m_lock[m] != 0) && fire[m] && last[m];
      ofree[m] = (m_lock[m] == 0) || rel[m];
      if (fire[m] && m_lock[m] == 0) n_err = 1;
      if (rel[m]) n_lock[m] = 0;
    end
    for (int n = 0; n < 4; n++) begin
      ifree[n] = (m_busy[n] == 0) || rel[m_dst[n]];
      if (m_busy[n] != 0 && rel[m_dst[n]]) n_busy[n] = 0;
    end
    for (int m = 0; m < 4; m++) begin
      gv[m] = 0; gid[m] = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_gp[m] + k) % 4;
        if (!gv[m] && ofree[m] && ifree[c] && req[c][m] && MAPV[c*4+m]) begin
          gv[m] = 1; gid[m] = c;
        end
      end
    end
    for (int n = 0; n < 4; n++) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ap[n] + k) % 4;
        if (!found && gv[c] && gid[c] == n) begin
          found = 1;
          n_lock[c] = 1; n_src[c] = n; n_busy[n] = 1; n_dst[n] = c;
          n_gp[c] = (n + 1) % 4; n_ap[n] = (c + 1) % 4;
        end
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    m_lock = n_lock; m_src = n_src; m_busy = n_busy; m_dst = n_dst;
    m_gp = n_gp; m_ap = n_ap; m_err = n_err;
    @(negedge clk);
  endtask

  task automatic clr_in();
    req = '0; fire = '0; last = '0; rst = 1'b0; flush = 1'b0;
  endtask

  // Per-cycle compare of every registered output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ev, eb;
      logic [3:0][1:0] es, ed;
      for (int i = 0; i < 4; i++) begin
        ev[i] = (m_lock[i] != 0);
        eb[i] = (m_busy[i] != 0);
        es[i] = 2'(m_src[i]);
        ed[i] = 2'(m_dst[i]);
      end
      chk("cmp_valid", 32'(mvalid), 32'(ev));
      chk("cmp_src",   32'(msrc),   32'(es));
      chk("cmp_busy",  32'(ibusy),  32'(eb));
      chk("cmp_dest",  32'(idest),  32'(ed));
      chk("cmp_err",   32'(err),    32'(m_err));
    end
  end

  initial begin
    int fair_exp[6];
    fair_exp = '{0, 1, 2, 0, 1, 2};
    clr_in();
    rst = 1'b1;
    @(negedge clk);
    tick();
    chk_en = 1;
    tick();
    chk("rst_valid", 32'(mvalid), 0);
    chk("rst_src",   32'(msrc),   0);
    chk("rst_busy",  32'(ibusy),  0);
    chk("rst_dest",  32'(idest),  0);
    chk("rst_err",   32'(err),    0);
    rst = 1'b0;

    // Single multi-beat packet 1 -> 2.
    req[1][2] = 1'b1;
    tick();
    req = '0;
    chk("sp_valid", 32'(mvalid), 32'h4);
    chk("sp_src2",  32'(msrc[2]), 1);
    chk("sp_busy",  32'(ibusy), 32'h2);
    chk("sp_dest1", 32'(idest[1]), 2);
    tick();
    fire[2] = 1'b1;
    tick();
    chk("sp_hold1", 32'(mvalid), 32'h4);
    tick();
    chk("sp_hold2", 32'(mvalid), 32'h4);
    last[2] = 1'b1;
    tick();
    clr_in();
    chk("sp_rel_valid", 32'(mvalid), 0);
    chk("sp_rel_busy",  32'(ibusy), 0);

    // Round-robin fairness on output 3 with single-beat packets.
    rst = 1'b1; tick(); rst = 1'b0;
    req[0][3] = 1'b1; req[1][3] = 1'b1; req[2][3] = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("rr_src3",   32'(msrc[3]), 32'(fair_exp[i]));
      chk("rr_valid3", 32'(mvalid[3]), 1);
      fire[3] = 1'b1; last[3] = 1'b1;
      tick();
    end
    clr_in();

    // Accept conflict: input 0 grabs output 1, output 2 left idle, then 0 -> 2.
    rst = 1'b1; tick(); rst = 1'b0;
    req[0] = 4'b0110; req[1] = 4'b0010;
    tick();
    chk("ac_valid", 32'(mvalid), 32'h2);
    chk("ac_src1",  32'(msrc[1]), 0);
    chk("ac_busy",  32'(ibusy), 32'h1);
    chk("ac_dest0", 32'(idest[0]), 1);
    req[0] = 4'b0100; req[1] = 4'b0000;
    fire[1] = 1'b1; last[1] = 1'b1;
    tick();
    clr_in();
    chk("ac2_valid", 32'(mvalid), 32'h4);
    chk("ac2_src2",  32'(msrc[2]), 0);
    chk("ac2_dest0", 32'(idest[0]), 2);
    chk("ac2_busy",  32'(ibusy), 32'h1);

    // Masked pair 3 -> 0 never matches; input 2 still can.
    rst = 1'b1; tick(); rst = 1'b0;
    req[3][0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("map_valid0", 32'(mvalid[0]), 0);
      chk("map_busy3",  32'(ibusy[3]), 0);
    end
    req[2][0] = 1'b1;
    tick();
    chk("map_other_valid0", 32'(mvalid[0]), 1);
    chk("map_other_src0",   32'(msrc[0]), 2);
    clr_in();

    // Protocol error is sticky; matching continues; flush clears everything.
    rst = 1'b1; tick(); rst = 1'b0;
    fire[0] = 1'b1; req[1][1] = 1'b1;
    tick();
    clr_in();
    chk("err_set",   32'(err), 1);
    chk("err_match", 32'(mvalid), 32'h2);
    chk("err_src1",  32'(msrc[1]), 1);
    tick(); tick();
    chk("err_sticky", 32'(err), 1);
    req[0][0] = 1'b1;
    tick();
    req = '0;
    chk("fl_pre_valid", 32'(mvalid), 32'h3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(mvalid), 0);
    chk("fl_busy",  32'(ibusy), 0);
    chk("fl_err",   32'(err), 0);
    req[0][0] = 1'b1; req[2][0] = 1'b1;
    tick();
    clr_in();
    chk("fl_ptr_src0", 32'(msrc[0]), 0);
    chk("fl_ptr_valid", 32'(mvalid), 32'h1);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 149) == 0);
      for (int n = 0; n < 4; n++)
        for (int m = 0; m < 4; m++)
          req[n][m] = ($urandom_range(0, 9) < 3);
      for (int m = 0; m < 4; m++) begin
        if (m_lock[m] != 0) fire[m] = ($urandom_range(0, 9) < 6);
        else                fire[m] = ($urandom_range(0, 59) == 0);
        last[m] = ($urandom_range(0, 9) < 4);
      end
      tick();
    end
    clr_in();
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gnrc_xbar_sched.md
# gnrc_xbar_sched

Packet-level scheduler for an N_IN × N_OUT stream crossbar. It takes per-input virtual-output-queue request vectors and computes a conflict-free input→output matching with a single-iteration iSLIP algorithm: round-robin grant, then round-robin accept. Each match is held until the last beat of the packet has been handshaked on the output. It sits beside the crossbar datapath: it drives the demux destinations and the output-mux selects, and it observes output handshakes to release connections.

## Interface
- N_IN, 4, number of inputs, >=2
- N_OUT, 4, number of outputs, >=2
- MAP, all ones, N_IN×N_OUT connectivity bit map; MAP[n][m]=1 allows input n → output m
- DEST_T, logic [$clog2(N_OUT)-1:0], output index type (auto-gen, do not change)
- ID_T, logic [$clog2(N_IN)-1:0], input index type (auto-gen, do not change)

- clk_i  in  1  clock, rising edge; single clock domain
- rst_i  in  1  synchronous reset, active high
- flush_i  in  1  synchronous clear of all matches, pointers and error flag
- req_i  in  N_IN×N_OUT  req_i[n][m]=1: input n has a packet head for output m
- fire_i  in  N_OUT  beat handshaked on output m (valid&ready)
- last_i  in  N_OUT  the handshaked beat on output m is last
- match_valid_o  out  N_OUT  output m currently connected
- match_src_o  out  N_OUT×ID_T  input connected to output m
- in_busy_o  out  N_IN  input n currently connected
- in_dest_o  out  N_IN×DEST_T  output connected to input n
- err_o  out  1  sticky protocol error

## Operation
- State, all registers:
  - per-output lock[m] and src[m]
  - per-input busy[n] and dst[n]
  - grant pointers g_ptr[m] (ID_T)
  - accept pointers a_ptr[n] (DEST_T)
  - err
- Release: rel[m] = lock[m] & fire_i[m] & last_i[m].
- Freeing: output m is free if ~lock[m] | rel[m]. Input n is free if ~busy[n], or its dst output is releasing.
- Request phase: eff[n][m] = req_i[n][m] & MAP[n][m] & in_free[n] & out_free[m].
- Grant phase: each free output m picks the first n with eff[n][m]=1, searching circularly from g_ptr[m].
- Accept phase: each input n picks the first granting m, searching circularly from a_ptr[n].
- On accept (n,m), at the next edge:
  - lock[m]=1, src[m]=n, busy[n]=1, dst[n]=m
  - g_ptr[m]=(n+1) mod N_IN, a_ptr[n]=(m+1) mod N_OUT
- Pointers move only on accept; a grant that is not accepted leaves g_ptr unchanged.
- Released pairs with no new accept clear lock/busy at the next edge.
- Single iteration per cycle. A free output whose grant was declined stays unmatched that cycle.
- req_i changes while locked are ignored. The match holds until rel.
- Error cases, both set err_o; lock state is not altered by them:
  - fire_i[m] while lock[m]=0
  - MAP[src][m]=0 cannot occur by construction
- MAP=0 pairs never match. An output with an all-zero MAP column stays match_valid_o=0 forever.
- Outputs are direct register values: match_valid_o=lock, match_src_o=src, in_busy_o=busy, in_dest_o=dst, err_o=err.

## Timing
- Reset (rst_i=1 at an edge), all zero:
  - match_valid_o, match_src_o, in_busy_o, in_dest_o, err_o
  - g_ptr, a_ptr
- flush_i has the same effect as reset. When both are asserted, the result is identical.
- Latency:
  - req_i asserted in cycle t → match visible at t+1.
  - rel in cycle t → connection dropped at t+1.
- Back-to-back: a release and a new accept on the same output in cycle t → the new src is visible at t+1 with no bubble.
- The same holds for an input: it may release output a and accept output b in one cycle.
- Single-beat packets: fire_i&last_i in the first matched cycle releases immediately.
- No combinational path from req_i, fire_i or last_i to any output.
- fire_i/last_i may depend combinationally on match_* outputs, because those are registered.

## Test plan
- Reset/flush:
  - rst_i=1 for 2 cycles → all outputs 0.
  - Matched state, then flush_i pulse → at the next cycle all match_valid_o/in_busy_o are 0 and pointers are 0 (check via the next grant order).
- Single packet: req_i[1][2]=1 at cycle 0 → cycle 1: match_valid_o[2]=1, match_src_o[2]=1, in_busy_o[1]=1, in_dest_o[1]=2. Then:
  - fire_i[2] at cycles 2 and 3 → match held.
  - fire_i[2]&last_i[2] at cycle 4 → cycle 5: match_valid_o[2]=0, in_busy_o[1]=0.
- Round-robin fairness: inputs 0,1,2 hold req on output 3, each packet single-beat → match_src_o[3] = 0,1,2,0,1,2 on consecutive cycles, with match_valid_o[3] continuously 1.
- Accept conflict, from reset:
  - Input 0 requests outputs 1 and 2; input 1 requests output 1.
  - Cycle 1: only (0→1) matched; output 2 unmatched; g_ptr[1]=1, a_ptr[0]=2.
  - After (0→1) releases, with input 0 requesting output 2 → (0→2) matches the next cycle.
- MAP mask: MAP[3][0]=0, req_i[3][0]=1 held 20 cycles → match_valid_o[0]=0 and in_busy_o[3]=0 throughout. Other inputs requesting output 0 still match.
- Protocol error: fire_i[0]=1 while match_valid_o[0]=0 → err_o=1 the next cycle, staying 1 until flush_i or rst_i. Matching continues normally.
